stack_transfer_sequencer: RTL and testbench

STACK_TRANSFER_SEQUENCER -- requirements
Module: stack_transfer_sequencer

---
 rtl/stack_transfer_sequencer.sv | 154 +++++++++++++++
 tb/tb_stack_transfer_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/stack_transfer_sequencer.sv
// Multi-register PUSH/POP sequencer: bounds-checks the stack, then moves one word per
// cycle between the register file and memory in ascending order, and finally writes back SP.
module stack_transfer_sequencer #(
  parameter int ADDR_WIDTH          = 32,
  parameter int DATA_WIDTH          = 32,
  parameter int KERNEL_STACK_TOP    = 4096,
  parameter int KERNEL_STACK_BOTTOM = 6143,
  parameter int USER_STACK_TOP      = 6144,
  parameter int USER_STACK_BOTTOM   = 8191
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_pop,
  input  logic [8:0]            reg_list,
  input  logic                  is_kernel,
  input  logic [DATA_WIDTH-1:0] sp_in,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic [3:0]            reg_index,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  reg_we,
  output logic [DATA_WIDTH-1:0] sp_out,
  output logic                  sp_we,
  output logic                  busy,
  output logic                  done,
  output logic                  fault
);

  localparam int XW = DATA_WIDTH + 1;
  localparam logic [XW-1:0] K_TOP = XW'(KERNEL_STACK_TOP);
  localparam logic [XW-1:0] K_BOT = XW'(KERNEL_STACK_BOTTOM);
  localparam logic [XW-1:0] U_TOP = XW'(USER_STACK_TOP);
  localparam logic [XW-1:0] U_BOT = XW'(USER_STACK_BOTTOM);

  typedef enum logic [1:0] {IDLE, CHECK, XFER, FINISH} state_t;

  state_t                  state, next_state;
  logic                    pop_q, kernel_q, fault_q, skip_q;
  logic [8:0]              mask_q;
  logic [DATA_WIDTH-1:0]   sp_q, sp_res_q, addr_q;
  logic                    pend_q;
  logic [3:0]              pend_idx_q;

  logic [XW-1:0]           top_x, bot_x, esp_x, n_x;
  logic [3:0]              n, cur_bit, cur_index;
  logic                    chk_fault, last_xfer;

  // Bounds arithmetic is one bit wider than SP so ESP-N / ESP+N can never wrap.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    cur_bit = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (mask_q[i]) cur_bit = 4'(i);
    end
    cur_index = (cur_bit == 4'd8) ? (pop_q ? 4'd15 : 4'd14) : cur_bit;
    last_xfer = ((mask_q & (mask_q - 9'd1)) == 9'd0);
    n         = 4'($countones(mask_q));
    n_x       = XW'(n);
    top_x     = kernel_q ? K_TOP : U_TOP;
    bot_x     = kernel_q ? K_BOT : U_BOT;
    esp_x     = (sp_q == '0) ? bot_x + XW'(1) : {1'b0, sp_q};
    chk_fault = pop_q ? (esp_x + n_x > bot_x + XW'(1)) : (esp_x < top_x + n_x);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      pend_q <= 1'b0;
    end else begin
      state  <= next_state;
      pend_q <= (state == XFER) && pop_q;
    end
  end

  // NOTE: datapath registers carry no reset; they are only observed in states the control path gates.
  always_ff @(posedge clock) begin
    pend_idx_q <= cur_index;
    case (state)
      IDLE: if (start) begin
        pop_q    <= is_pop;
        mask_q   <= reg_list;
        kernel_q <= is_kernel;
        sp_q     <= sp_in;
      end
      CHECK: begin
        fault_q  <= chk_fault;
        skip_q   <= (n == 4'd0);
        addr_q   <= pop_q ? DATA_WIDTH'(esp_x) : DATA_WIDTH'(esp_x - n_x);
        sp_res_q <= pop_q ? DATA_WIDTH'(esp_x + n_x) : DATA_WIDTH'(esp_x - n_x);
      end
      XFER: begin
        mask_q <= mask_q & (mask_q - 9'd1);
        addr_q <= addr_q + DATA_WIDTH'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    next_state  = state;
    busy        = (state != IDLE);
    mem_address = '0;
    mem_wdata   = '0;
    mem_we      = 1'b0;
    reg_index   = 4'd0;
    reg_wdata   = '0;
    reg_we      = 1'b0;
    sp_out      = '0;
    sp_we       = 1'b0;
    done        = 1'b0;
    fault       = 1'b0;
    case (state)
      IDLE:   if (start) next_state = CHECK;
      CHECK:  next_state = (chk_fault || n == 4'd0) ? FINISH : XFER;
      XFER: begin
        mem_address = ADDR_WIDTH'(addr_q);
        if (!pop_q) begin
          mem_we    = 1'b1;
          mem_wdata = reg_rdata;
          reg_index = cur_index;
        end
        if (last_xfer) next_state = FINISH;
      end
      FINISH: begin
        done       = 1'b1;
        fault      = fault_q;
        sp_we      = !fault_q && !skip_q;
        sp_out     = (!fault_q && !skip_q) ? sp_res_q : '0;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // A POP's register writeback trails its memory read by one cycle.
    if (pend_q) begin
      reg_we    = 1'b1;
      reg_wdata = mem_rdata;
      reg_index = pend_idx_q;
    end
    // An abort suppresses strobes already in the cycle reset is sampled.
    if (reset) begin
      mem_we = 1'b0;
      reg_we = 1'b0;
      sp_we  = 1'b0;
      done   = 1'b0;
      fault  = 1'b0;
    end
  end

endmodule

// File: tb/tb_stack_transfer_sequencer.sv
// Scoreboard bench for stack_transfer_sequencer: stimulus queues timed expected events,
// a negedge monitor pops and compares every mem write, reg write and done it observes.
module tb_stack_transfer_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_pop = 1'b0;
  logic        is_kernel = 1'b0;
  logic [8:0]  reg_list = 9'd0;
  logic [31:0] sp_in = 32'd0;
  logic [31:0] reg_rdata;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] mem_address, mem_wdata, reg_wdata, sp_out;
  logic [3:0]  reg_index;
  logic        mem_we, reg_we, sp_we, busy, done, fault;

  stack_transfer_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .is_pop(is_pop), .reg_list(reg_list),
    .is_kernel(is_kernel), .sp_in(sp_in), .reg_rdata(reg_rdata), .mem_rdata(mem_rdata),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .reg_index(reg_index), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .sp_out(sp_out), .sp_we(sp_we), .busy(busy), .done(done), .fault(fault)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Register file: register i reads as C0DE_000i. Memory: synchronous, one-cycle read.
  assign reg_rdata = 32'hC0DE_0000 | 32'(reg_index);
  bit [31:0] mem [0:8191];
  always @(posedge clock) begin
    if (mem_we) mem[mem_address[12:0]] <= mem_wdata;
    mem_rdata <= mem[mem_address[12:0]];
  end

  int checks = 0;
  int fails  = 0;

  typedef struct {
    int          cyc;
    int          kind;   // 0 mem write, 1 reg write, 2 done
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  f;      // {fault, sp_we} for done
  } ev_t;
  ev_t exp_q[$];

  task automatic expect_ev(input int c, input int kind, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] f);
    ev_t e;
    e.cyc = c; e.kind = kind; e.a = a; e.d = d; e.f = f;
    exp_q.push_back(e);
  endtask

  task automatic sb_compare(input int kind, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] f);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event kind=%0d cycle=%0d a=%0d d=%h f=%b, required none",
               kind, cyc, a, d, f);
    end else begin
      e = exp_q.pop_front();
      if (e.cyc != cyc || e.kind != kind || e.a !== a || e.d !== d || e.f !== f) begin
        fails++;
        $display("FAIL event got kind=%0d cycle=%0d a=%0d d=%h f=%b, required kind=%0d cycle=%0d a=%0d d=%h f=%b",
                 kind, cyc, a, d, f, e.kind, e.cyc, e.a, e.d, e.f);
      end
    end
  endtask

  always @(negedge clock) begin
    if (mem_we) sb_compare(0, mem_address, mem_wdata, 2'b00);
    if (reg_we) sb_compare(1, 32'(reg_index), reg_wdata, 2'b00);
    if (done)   sb_compare(2, 32'd0, sp_out, {fault, sp_we});
    if (fault && !done) begin
      checks++;
      fails++;
      $display("FAIL fault_without_done cycle=%0d got fault=1, required 0", cyc);
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {mem_address, mem_wdata, mem_we, reg_index, reg_wdata, reg_we,
            sp_out, sp_we, busy, done, fault};
  endfunction

  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Drives start for exactly one cycle; c is the cycle in which start was high.
  task automatic pulse(input logic p, input logic [8:0] list, input logic k,
                       input logic [31:0] sp, output int c);
    @(posedge clock); #1;
    is_pop = p; reg_list = list; is_kernel = k; sp_in = sp; start = 1'b1;
    c = cyc;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  initial begin
    int c;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_outputs_zero", all_outs(), '0);

    // User PUSH {r0,r2,r14} from an SP of 8192; a start during FINISH must be ignored.
    pulse(1'b0, 9'h105, 1'b0, 32'd8192, c);
    expect_ev(c + 2, 0, 32'd8189, 32'hC0DE_0000, 2'b00);
    expect_ev(c + 3, 0, 32'd8190, 32'hC0DE_0002, 2'b00);
    expect_ev(c + 4, 0, 32'd8191, 32'hC0DE_000E, 2'b00);
    expect_ev(c + 5, 2, 32'd0,    32'd8189,      2'b01);
    @(negedge clock);
    check("busy_in_check", 128'(busy), 128'd1);
    wait_to(c + 5);
    is_pop = 1'b0; reg_list = 9'h001; sp_in = 32'd8192; start = 1'b1;
    wait_to(c + 6);
    start = 1'b0;
    @(negedge clock);
    check("start_in_finish_ignored", 128'(busy), 128'd0);
    wait_to(c + 9);

    // User POP {r0,r2,r15} from 8189 reads back what the PUSH left at 8189..8191.
    pulse(1'b1, 9'h105, 1'b0, 32'd8189, c);
    expect_ev(c + 3, 1, 32'd0,  32'hC0DE_0000, 2'b00);
    expect_ev(c + 4, 1, 32'd2,  32'hC0DE_0002, 2'b00);
    expect_ev(c + 5, 1, 32'd15, 32'hC0DE_000E, 2'b00);
    expect_ev(c + 5, 2, 32'd0,  32'd8192,      2'b01);
    wait_to(c + 8);

    // Kernel PUSH of 3: 4098 overflows below 4096, 4099 lands exactly on the top word.
    pulse(1'b0, 9'h007, 1'b1, 32'd4098, c);
    expect_ev(c + 2, 2, 32'd0, 32'd0, 2'b10);
    wait_to(c + 5);
    pulse(1'b0, 9'h007, 1'b1, 32'd4099, c);
    expect_ev(c + 2, 0, 32'd4096, 32'hC0DE_0000, 2'b00);
    expect_ev(c + 3, 0, 32'd4097, 32'hC0DE_0001, 2'b00);
    expect_ev(c + 4, 0, 32'd4098, 32'hC0DE_0002, 2'b00);
    expect_ev(c + 5, 2, 32'd0,    32'd4096,      2'b01);
    wait_to(c + 8);

    // Empty user stack: POP faults, PUSH goes to the bottom word.
    pulse(1'b1, 9'h002, 1'b0, 32'd0, c);
    expect_ev(c + 2, 2, 32'd0, 32'd0, 2'b10);
    wait_to(c + 5);
    pulse(1'b0, 9'h002, 1'b0, 32'd0, c);
    expect_ev(c + 2, 0, 32'd8191, 32'hC0DE_0001, 2'b00);
    expect_ev(c + 3, 2, 32'd0,    32'd8191,      2'b01);
    wait_to(c + 6);

    // Empty register list: done without fault or writeback.
    pulse(1'b0, 9'h000, 1'b0, 32'd8000, c);
    expect_ev(c + 2, 2, 32'd0, 32'd0, 2'b00);
    wait_to(c + 5);

    // PUSH of 4 aborted by reset at c+3 while start is pulsed again.
    pulse(1'b0, 9'h00F, 1'b0, 32'd8192, c);
    expect_ev(c + 2, 0, 32'd8188, 32'hC0DE_0000, 2'b00);
    wait_to(c + 3);
    start = 1'b1; reset = 1'b1;
    wait_to(c + 4);
    start = 1'b0; reset = 1'b0;
    @(negedge clock);
    check("abort_outputs_zero", all_outs(), '0);
    wait_to(c + 5);
    is_pop = 1'b0; reg_list = 9'h020; is_kernel = 1'b0; sp_in = 32'd8192; start = 1'b1;
    expect_ev(c + 7, 0, 32'd8191, 32'hC0DE_0005, 2'b00);
    expect_ev(c + 8, 2, 32'd0,    32'd8191,      2'b01);
    wait_to(c + 6);
    start = 1'b0;
    @(negedge clock);
    check("restart_after_abort_busy", 128'(busy), 128'd1);
    wait_to(c + 12);

    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
